// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension, register-file write port,
// decode operand bypass (enabled by WB_BYPASS_EN) and a retired-instruction counter.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              Clrn,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic              m_reg_write,
  input  logic [REG_AW-1:0] m_rd,
  input  logic [DATA_W-1:0] m_alu,
  input  logic              m_is_load,
  input  logic [1:0]        m_ld_size,
  input  logic              m_ld_uns,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [REG_AW-1:0] wb_wn,
  output logic [DATA_W-1:0] wb_d,
  output logic              wb_we,
  input  logic [REG_AW-1:0] rna,
  input  logic [REG_AW-1:0] rnb,
  input  logic [DATA_W-1:0] rf_qa,
  input  logic [DATA_W-1:0] rf_qb,
  output logic [DATA_W-1:0] qa_o,
  output logic [DATA_W-1:0] qb_o,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              is_load_q, is_load_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_uns_q, ld_uns_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ld_ext_s;

  // Select byte/half/word from the raw memory word and sign- or zero-extend it.
  function automatic logic [DATA_W-1:0] ld_extend(input logic [DATA_W-1:0] rdata,
                                                  input logic [1:0] a,
                                                  input logic [1:0] size,
                                                  input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DATA_W-1:0] r;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Next-state: flush kills, stall holds, otherwise capture the MEM stage.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    is_load_d   = is_load_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;
    rdata_d     = rdata_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d     = m_valid;
      reg_write_d = m_reg_write;
      rd_d        = m_rd;
      alu_d       = m_alu;
      is_load_d   = m_is_load;
      ld_size_d   = m_ld_size;
      ld_uns_d    = m_ld_uns;
      rdata_d     = m_rdata;
    end
    if (valid_q && !stall && !flush) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // WB pipeline registers and retire counter.
  always_ff @(posedge clk or negedge Clrn) begin
    if (!Clrn) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= {REG_AW{1'b0}};
      alu_q       <= {DATA_W{1'b0}};
      is_load_q   <= 1'b0;
      ld_size_q   <= 2'b00;
      ld_uns_q    <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      is_load_q   <= is_load_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ld_ext_s   = ld_extend(rdata_q, alu_q[1:0], ld_size_q, ld_uns_q);
  assign wb_we      = valid_q & reg_write_q & (rd_q != {REG_AW{1'b0}});
  assign wb_wn      = rd_q;
  assign wb_d       = is_load_q ? ld_ext_s : alu_q;
  assign retire_cnt = cnt_q;

`ifdef WB_BYPASS_EN
  // Forward the value being written this cycle to a matching decode read.
  assign qa_o = ((rna != {REG_AW{1'b0}}) && wb_we && (rna == wb_wn)) ? wb_d : rf_qa;
  assign qb_o = ((rnb != {REG_AW{1'b0}}) && wb_we && (rnb == wb_wn)) ? wb_d : rf_qb;
`else
  logic unused_rn_s;
  assign unused_rn_s = ^{rna, rnb};
  assign qa_o = rf_qa;
  assign qb_o = rf_qb;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, stall/flush/bypass/wrap
// sequences and randomized traffic against a behavioural model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic Clrn, stall, flush, m_valid, m_reg_write, m_is_load, m_ld_uns;
  logic [4:0]  m_rd, rna, rnb, wb_wn, wb_wn4;
  logic [31:0] m_alu, m_rdata, rf_qa, rf_qb, wb_d, qa_o, qb_o, retire_cnt;
  logic [31:0] wb_d4, qa4, qb4;
  logic [1:0]  m_ld_size;
  logic        wb_we, wb_we4;
  logic [3:0]  cnt4;
  int pass_cnt = 0, total_cnt = 0;

  // model state
  logic        e_valid, e_rw, e_ld, e_uns, e_known;
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_rdata, e_cnt;
  logic [1:0]  e_size;

  always #5 clk = ~clk;

  mem_wb_stage dut (.clk(clk), .Clrn(Clrn), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_reg_write(m_reg_write), .m_rd(m_rd), .m_alu(m_alu), .m_is_load(m_is_load),
    .m_ld_size(m_ld_size), .m_ld_uns(m_ld_uns), .m_rdata(m_rdata), .wb_wn(wb_wn), .wb_d(wb_d),
    .wb_we(wb_we), .rna(rna), .rnb(rnb), .rf_qa(rf_qa), .rf_qb(rf_qb), .qa_o(qa_o), .qb_o(qb_o),
    .retire_cnt(retire_cnt));

  mem_wb_stage #(.CNT_W(4)) dut4 (.clk(clk), .Clrn(Clrn), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd), .m_alu(m_alu),
    .m_is_load(m_is_load), .m_ld_size(m_ld_size), .m_ld_uns(m_ld_uns), .m_rdata(m_rdata),
    .wb_wn(wb_wn4), .wb_d(wb_d4), .wb_we(wb_we4), .rna(rna), .rnb(rnb), .rf_qa(rf_qa),
    .rf_qb(rf_qb), .qa_o(qa4), .qb_o(qb4), .retire_cnt(cnt4));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        ld;
    logic [1:0]  size;
    logic        uns;
    logic        exp_we;
    logic [31:0] exp_d;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [31:0] ref_ext(logic [31:0] rdata, logic [1:0] a, logic [1:0] size,
                                          logic uns);
    longint unsigned r, sel, w;
    r = rdata;
    if (size == 2'd0) begin
      w = 8; sel = (r >> (8 * a)) % 256;
    end else if (size == 2'd1) begin
      w = 16; sel = (r >> (16 * (a / 2))) % 65536;
    end else begin
      w = 32; sel = r;
    end
    if (!uns && w < 32 && sel >= (64'd1 << (w - 1))) sel = sel + (64'd1 << 32) - (64'd1 << w);
    return sel[31:0];
  endfunction

  function automatic logic exp_we();
    return e_valid && e_rw && (e_rd != 5'd0);
  endfunction

  function automatic logic [31:0] exp_d();
    return e_ld ? ref_ext(e_rdata, e_alu[1:0], e_size, e_uns) : e_alu;
  endfunction

  function automatic logic [31:0] exp_q(logic [4:0] rn, logic [31:0] rf);
`ifdef WB_BYPASS_EN
    if (rn != 5'd0 && exp_we() && rn == e_rd) return exp_d();
`endif
    return rf;
  endfunction

  task automatic model_reset();
    e_valid = 1'b0; e_rw = 1'b0; e_ld = 1'b0; e_uns = 1'b0; e_rd = 5'd0;
    e_alu = 32'd0; e_rdata = 32'd0; e_size = 2'd0; e_cnt = 32'd0; e_known = 1'b1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    logic ret;
    ret = e_valid && !stall && !flush;
    @(posedge clk);
    if (!Clrn) model_reset();
    else begin
      if (ret) e_cnt = e_cnt + 32'd1;
      if (flush) begin
        e_valid = 1'b0; e_known = 1'b0;
      end else if (!stall) begin
        e_valid = m_valid; e_rw = m_reg_write; e_rd = m_rd; e_alu = m_alu; e_ld = m_is_load;
        e_size = m_ld_size; e_uns = m_ld_uns; e_rdata = m_rdata; e_known = 1'b1;
      end
    end
    #1;
  endtask

  task automatic check_all(string tag);
    chk({tag, "_we"}, {31'd0, wb_we}, {31'd0, exp_we()});
    if (e_known) begin
      chk({tag, "_wn"}, {27'd0, wb_wn}, {27'd0, e_rd});
      chk({tag, "_d"}, wb_d, exp_d());
    end
    chk({tag, "_cnt"}, retire_cnt, e_cnt);
    chk({tag, "_cnt4"}, {28'd0, cnt4}, {28'd0, e_cnt[3:0]});
    chk({tag, "_qa"}, qa_o, exp_q(rna, rf_qa));
    chk({tag, "_qb"}, qb_o, exp_q(rnb, rf_qb));
  endtask

  task automatic set_op(logic [4:0] rd, logic [31:0] alu, logic ld, logic [1:0] size, logic uns);
    m_valid = 1'b1; m_reg_write = 1'b1; m_rd = rd; m_alu = alu;
    m_is_load = ld; m_ld_size = size; m_ld_uns = uns;
  endtask

  initial begin
    vecs[0] = '{5'd5,  32'h1234_5678, 1'b0, 2'd0, 1'b0, 1'b1, 32'h1234_5678};
    vecs[1] = '{5'd3,  32'h0000_0000, 1'b1, 2'd0, 1'b0, 1'b1, 32'hFFFF_FF81};
    vecs[2] = '{5'd3,  32'h0000_0003, 1'b1, 2'd0, 1'b1, 1'b1, 32'h0000_0080};
    vecs[3] = '{5'd4,  32'h0000_0002, 1'b1, 2'd1, 1'b0, 1'b1, 32'hFFFF_80FF};
    vecs[4] = '{5'd6,  32'h0000_0001, 1'b1, 2'd2, 1'b0, 1'b1, 32'h80FF_7F81};
    vecs[5] = '{5'd0,  32'h0000_0099, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0000_0099};
    vecs[6] = '{5'd9,  32'h0000_0001, 1'b1, 2'd1, 1'b1, 1'b1, 32'h0000_7F81};
    vecs[7] = '{5'd10, 32'h0000_0002, 1'b1, 2'd0, 1'b0, 1'b1, 32'hFFFF_FFFF};

    // reset with valid traffic and running clock
    Clrn = 1'b0; stall = 1'b0; flush = 1'b0; m_rdata = 32'h80FF_7F81;
    rna = 5'd0; rnb = 5'd0; rf_qa = 32'h0; rf_qb = 32'h0;
    set_op(5'd5, 32'h1234_5678, 1'b0, 2'd0, 1'b0);
    model_reset();
    repeat (3) tick();
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_d", wb_d, 32'd0);
    chk("rst_wn", {27'd0, wb_wn}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    Clrn = 1'b1;

    // directed vector table
    for (int i = 0; i < 8; i++) begin
      set_op(vecs[i].rd, vecs[i].alu, vecs[i].ld, vecs[i].size, vecs[i].uns);
      tick();
      chk($sformatf("vec%0d_we", i), {31'd0, wb_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_wn", i), {27'd0, wb_wn}, {27'd0, vecs[i].rd});
      chk($sformatf("vec%0d_d", i), wb_d, vecs[i].exp_d);
      check_all($sformatf("vec%0d", i));
    end

    // r0 write still retires
    set_op(5'd0, 32'h0000_0042, 1'b0, 2'd0, 1'b0);
    tick(); tick();
    check_all("r0");

    // stall three cycles freezes WB outputs and counter
    set_op(5'd12, 32'h0000_0055, 1'b0, 2'd0, 1'b0);
    tick();
    stall = 1'b1;
    set_op(5'd13, 32'h0000_0066, 1'b0, 2'd0, 1'b0);
    begin
      logic [31:0] held_cnt;
      held_cnt = e_cnt;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("stall_we", {31'd0, wb_we}, 32'd1);
        chk("stall_wn", {27'd0, wb_wn}, 32'd12);
        chk("stall_d", wb_d, 32'h0000_0055);
        chk("stall_cnt", retire_cnt, held_cnt);
      end
    end

    // flush together with stall kills the instruction
    flush = 1'b1;
    tick();
    chk("flush_we", {31'd0, wb_we}, 32'd0);
    check_all("flush");
    stall = 1'b0; flush = 1'b0;

    // bypass of the value being written back
    set_op(5'd7, 32'hAAAA_AAAA, 1'b0, 2'd0, 1'b0);
    tick();
    rna = 5'd7; rf_qa = 32'h0; rnb = 5'd0; rf_qb = 32'h1234_5678;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_qa", qa_o, 32'hAAAA_AAAA);
`else
    chk("byp_qa", qa_o, 32'h0000_0000);
`endif
    chk("byp_qb", qb_o, 32'h1234_5678);

    // 4-bit counter wrap
    m_valid = 1'b1;
    for (int i = 0; i < 40 && e_cnt[3:0] != 4'hF; i++) tick();
    chk("wrap_pre", {28'd0, cnt4}, 32'd15);
    tick();
    chk("wrap", {28'd0, cnt4}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 5) == 0;
      flush = ($urandom % 7) == 0;
      m_valid = ($urandom % 4) != 0;
      m_reg_write = ($urandom % 4) != 0;
      m_rd = 5'($urandom % 8);
      m_alu = $urandom;
      m_is_load = $urandom % 2;
      m_ld_size = 2'($urandom % 4);
      m_ld_uns = $urandom % 2;
      m_rdata = $urandom;
      rna = 5'($urandom % 8); rnb = 5'($urandom % 8);
      rf_qa = $urandom; rf_qb = $urandom;
      tick();
      check_all("rnd");
      if (i == 200) begin
        #2 Clrn = 1'b0;
        #1;
        chk("midrst_cnt", retire_cnt, 32'd0);
        chk("midrst_cnt4", {28'd0, cnt4}, 32'd0);
        chk("midrst_we", {31'd0, wb_we}, 32'd0);
        model_reset();
        Clrn = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
